// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state type, state_o
// encodings, default parameter values and a small sizing helper.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  localparam logic [1:0] STATE_ENC_RESET     = 2'd0;
  localparam logic [1:0] STATE_ENC_WAIT_LOCK = 2'd1;
  localparam logic [1:0] STATE_ENC_RUN       = 2'd2;

  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_LOCK_STABLE  = 1024;
  localparam int DEF_LOCK_TIMEOUT = 65536;
  localparam int DEF_RETRY_W      = 4;
  localparam int DEF_LOSS_FILTER  = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-high reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; first one may go metastable, second resolves it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable synchronised
// lock, then releases the system reset. Lock loss, lock timeout or a relock
// request restart the sequence. Everything runs on refclk.
// Optional build macro PLL_SEQ_GLITCH_FILTER_EN: in RUN, lock loss needs
// LOSS_FILTER consecutive unlocked cycles instead of a single one.
//
// Handshake note: relock_req and clr_status are single-cycle pulses sampled
// on refclk; there is no ready/acknowledge, a pulse is acted on in the cycle
// it is high (relock_req is dropped while in RESET).
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int RETRY_W      = DEF_RETRY_W,
  parameter int LOSS_FILTER  = DEF_LOSS_FILTER
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               relock_req,
  input  logic               clr_status,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic [1:0]         state_o,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               lock_lost
);

  // One shared counter serves the reset pulse and the lock timeout.
  localparam int CNT_W  = max2(1, $clog2(max2(RST_CYCLES, LOCK_TIMEOUT)));
  localparam int STAB_W = max2(1, $clog2(LOCK_STABLE));

  // Configurations the counters cannot express are rejected at elaboration.
  if (RST_CYCLES < 1 || LOCK_STABLE < 1 || LOCK_TIMEOUT <= LOCK_STABLE ||
      RETRY_W < 1 || LOSS_FILTER < 1) begin : g_bad_params
    $error("pll_reset_sequencer: illegal parameter combination");
  end

  logic locked_s;

  sync_2ff u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STAB_W-1:0]  stab_q, stab_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               lost_q, lost_d;
  logic               pll_rst_q, sys_rst_q, ready_q;
  logic               retry_inc, lost_set, loss;

`ifdef PLL_SEQ_GLITCH_FILTER_EN
  localparam int LOSS_W = max2(1, $clog2(LOSS_FILTER));
  logic [LOSS_W-1:0] loss_q, loss_d;

  // Consecutive-unlocked counter used only while in RUN.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) loss_q <= '0;
    else     loss_q <= loss_d;
  end

  // Loss only after LOSS_FILTER unlocked cycles in a row.
  always_comb begin
    loss_d = '0;
    loss   = 1'b0;
    if (state_q == ST_RUN && !locked_s) begin
      if (loss_q == LOSS_W'(LOSS_FILTER - 1)) loss = 1'b1;
      else                                    loss_d = loss_q + 1'b1;
    end
  end
`else
  // A single unlocked cycle in RUN is lock loss.
  always_comb begin
    loss = (state_q == ST_RUN) && !locked_s;
  end
`endif

  // State, counters and status registers; outputs load from the next state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      stab_q    <= '0;
      retry_q   <= '0;
      lost_q    <= 1'b0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stab_q    <= stab_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      pll_rst_q <= (state_d == ST_RESET);
      sys_rst_q <= (state_d != ST_RUN);
      ready_q   <= (state_d == ST_RUN);
    end
  end

  // Next-state, counter and status update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    stab_d    = '0;
    retry_inc = 1'b0;
    lost_set  = 1'b0;

    case (state_q)
      ST_RESET: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
        else                                 cnt_d   = cnt_q + 1'b1;
      end
      ST_WAIT_LOCK: begin
        cnt_d  = cnt_q + 1'b1;
        stab_d = locked_s ? stab_q + 1'b1 : '0;
        if (relock_req) begin
          state_d = ST_RESET;
          cnt_d   = '0;
          stab_d  = '0;
        end else if (locked_s && stab_q == STAB_W'(LOCK_STABLE - 1)) begin
          // Stable lock beats a timeout landing in the same cycle.
          state_d = ST_RUN;
          cnt_d   = '0;
          stab_d  = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d   = ST_RESET;
          cnt_d     = '0;
          stab_d    = '0;
          retry_inc = 1'b1;
        end
      end
      ST_RUN: begin
        if (loss || relock_req) begin
          state_d  = ST_RESET;
          lost_set = loss;
        end
      end
      default: state_d = ST_RESET;
    endcase

    // A clear and an event in the same cycle leave the event's effect.
    retry_d = retry_q;
    if (retry_inc) begin
      if (clr_status)          retry_d = RETRY_W'(1);
      else if (retry_q != '1)  retry_d = retry_q + 1'b1;
    end else if (clr_status) begin
      retry_d = '0;
    end

    lost_d = lost_q;
    if (lost_set)        lost_d = 1'b1;
    else if (clr_status) lost_d = 1'b0;
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign state_o   = state_q;
  assign retry_cnt = retry_q;
  assign lock_lost = lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer (honours PLL_SEQ_GLITCH_FILTER_EN).
module tb_pll_reset_sequencer;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 32;
  localparam int RETRY_W      = 4;
  localparam int LOSS_FILTER  = 4;

  // ---------------- clock / reset ----------------
  logic refclk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  logic relock_req = 1'b0;
  logic clr_status = 1'b0;
  logic pll_rst, sys_rst, ready, lock_lost;
  logic [1:0] state_o;
  logic [RETRY_W-1:0] retry_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 refclk = ~refclk;

  pll_reset_sequencer #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_STABLE  (LOCK_STABLE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .RETRY_W      (RETRY_W),
    .LOSS_FILTER  (LOSS_FILTER)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .clr_status (clr_status),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .state_o    (state_o),
    .retry_cnt  (retry_cnt),
    .lock_lost  (lock_lost)
  );

  // Observed outputs packed as {state, pll_rst, sys_rst, ready, lock_lost, retry}.
  function automatic logic [9:0] outs();
    return {state_o, pll_rst, sys_rst, ready, lock_lost, retry_cnt};
  endfunction

  function automatic logic [9:0] ev(input logic [1:0] st, input logic pr, input logic sr,
                                    input logic rd, input logic ll, input int rc);
    logic [3:0] r;
    r = 4'(rc);
    return {st, pr, sr, rd, ll, r};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Leaves the bench in cycle 0: rst released, no edge since.
  task automatic start_fresh();
    rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0; clr_status = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [9:0] e;
    rst = 1'b1;
    repeat (2) tick();
    e = ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    n_tests++; if (outs() !== e) begin n_fail++; $display("FAIL reset_values: got %h want %h", outs(), e); end
  endtask

  task automatic test_clean_start();
    logic [9:0] e;
    logic [1:0] st;
    start_fresh();
    for (int k = 0; k <= 24; k++) begin
      st = (k < 4) ? 2'd0 : (k < 20) ? 2'd1 : 2'd2;
      e  = ev(st, k < 4, k < 20, k >= 20, 1'b0, 0);
      n_tests++; if (outs() !== e) begin n_fail++; $display("FAIL clean_start cyc %0d: got %h want %h", k, outs(), e); end
      if (k == 10) pll_locked = 1'b1;
      if (k < 24) tick();
    end
  endtask

`ifdef PLL_SEQ_GLITCH_FILTER_EN
  task automatic test_glitch_filter();
    logic [9:0] e;
    e = ev(2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    pll_locked = 1'b0;
    repeat (3) tick();
    pll_locked = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (outs() !== e) begin n_fail++; $display("FAIL glitch3_ignored i=%0d: got %h want %h", i, outs(), e); end
      tick();
    end
    pll_locked = 1'b0;
    repeat (4) tick();
    pll_locked = 1'b1;
    tick();
    n_tests++; if (outs() !== e) begin n_fail++; $display("FAIL glitch4_before_loss: got %h want %h", outs(), e); end
    tick();
    e = ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    n_tests++; if (outs() !== e) begin n_fail++; $display("FAIL glitch4_loss: got %h want %h", outs(), e); end
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    n_tests++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL glitch_clr: got %b want 0", lock_lost); end
    repeat (10) tick();
    n_tests++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL glitch_relock_wait: got %0d want 1", state_o); end
    tick();
    e = ev(2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    n_tests++; if (outs() !== e) begin n_fail++; $display("FAIL glitch_relock_run: got %h want %h", outs(), e); end
  endtask
`else
  task automatic test_lock_loss();
    logic [9:0] e;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL loss_lat1: got %b want 1", ready); end
    tick();
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL loss_lat2: got %b want 1", ready); end
    tick();
    e = ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    n_tests++; if (outs() !== e) begin n_fail++; $display("FAIL loss_reset: got %h want %h", outs(), e); end
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    n_tests++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL loss_clr: got %b want 0", lock_lost); end
    repeat (10) tick();
    e = ev(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    n_tests++; if (outs() !== e) begin n_fail++; $display("FAIL loss_relock_wait: got %h want %h", outs(), e); end
    tick();
    e = ev(2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    n_tests++; if (outs() !== e) begin n_fail++; $display("FAIL loss_relock_run: got %h want %h", outs(), e); end
  endtask
`endif

  task automatic test_relock();
    logic [9:0] e;
    int width;
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    e = ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    n_tests++; if (outs() !== e) begin n_fail++; $display("FAIL relock_run: got %h want %h", outs(), e); end
    width = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      if (pll_rst === 1'b1) width++;
    end
    n_tests++; if (width != RST_CYCLES) begin n_fail++; $display("FAIL relock_pll_rst_width: got %0d want %0d", width, RST_CYCLES); end
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    e = ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    n_tests++; if (outs() !== e) begin n_fail++; $display("FAIL relock_in_wait: got %h want %h", outs(), e); end
    repeat (11) tick();
    n_tests++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL relock_wait: got %0d want 1", state_o); end
    tick();
    n_tests++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL relock_run_again: got %0d want 2", state_o); end
  endtask

  task automatic test_timeout();
    logic [9:0] e;
    start_fresh();
    for (int a = 1; a <= 17; a++) begin
      repeat (35) tick();
      e = ev(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, (a - 1 > 15) ? 15 : a - 1);
      n_tests++; if (outs() !== e) begin n_fail++; $display("FAIL timeout_wait a=%0d: got %h want %h", a, outs(), e); end
      tick();
      e = ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, (a > 15) ? 15 : a);
      n_tests++; if (outs() !== e) begin n_fail++; $display("FAIL timeout_retry a=%0d: got %h want %h", a, outs(), e); end
    end
  endtask

  task automatic test_clr_with_timeout();
    repeat (35) tick();
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    n_tests++; if (retry_cnt !== 4'd1 || state_o !== 2'd0) begin n_fail++; $display("FAIL clr_vs_timeout: got retry %0d state %0d want 1 0", retry_cnt, state_o); end
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    n_tests++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_alone: got %0d want 0", retry_cnt); end
    repeat (8) tick();
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    n_tests++; if (state_o !== 2'd0 || retry_cnt !== 4'd0) begin n_fail++; $display("FAIL relock_wait_no_retry: got state %0d retry %0d want 0 0", state_o, retry_cnt); end
    repeat (36) tick();
    n_tests++; if (state_o !== 2'd0 || retry_cnt !== 4'd1) begin n_fail++; $display("FAIL timeout_after_clr: got state %0d retry %0d want 0 1", state_o, retry_cnt); end
  endtask

  task automatic test_async_rst();
    logic [9:0] e;
    repeat (8) tick();
    n_tests++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL async_pre_wait: got %0d want 1", state_o); end
    #3 rst = 1'b1;
    #1;
    e = ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    n_tests++; if (outs() !== e) begin n_fail++; $display("FAIL async_rst: got %h want %h", outs(), e); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clean_start();
`ifdef PLL_SEQ_GLITCH_FILTER_EN
    test_glitch_filter();
`else
    test_lock_loss();
`endif
    test_relock();
    test_timeout();
    test_clr_with_timeout();
    test_async_rst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Supervises the 50 MHz-referenced PLL wrapper: drives its reset, qualifies its locked output and releases the system reset only after a stable lock.
- Re-runs the PLL reset on lock loss, lock timeout or software relock request; counts failed attempts.
- Runs entirely on refclk. sys_rst is a refclk-domain signal; downstream consumers on outclk_0 re-synchronise it.

Parameters:
- RST_CYCLES, 16, cycles pll_rst is held high per attempt (>=1)
- LOCK_STABLE, 1024, consecutive synchronised-locked cycles required before release (>=1)
- LOCK_TIMEOUT, 65536, cycles in WAIT_LOCK before the attempt is abandoned (>LOCK_STABLE)
- RETRY_W, 4, width of the retry counter
- LOSS_FILTER, 4, consecutive unlocked cycles treated as lock loss (used only with the optional feature)

Ports:
- refclk  in  1  reference clock; sole clock
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL locked output, asynchronous to refclk
- relock_req  in  1  single-cycle pulse requesting a fresh PLL reset
- clr_status  in  1  single-cycle pulse clearing lock_lost and retry_cnt
- pll_rst  out  1  to PLL rst
- sys_rst  out  1  active-high system reset
- ready  out  1  high while in RUN
- state_o  out  2  current state encoding
- retry_cnt  out  RETRY_W  timeouts since last clear, saturating
- lock_lost  out  1  sticky: lock dropped while in RUN

Behaviour:
- Reset interface: one clock; reset is asynchronous and active-high, ports refclk and rst.
- On rst: state RESET, pll_rst=1, sys_rst=1, ready=0, retry_cnt=0, lock_lost=0, all counters 0, synchroniser flops 0.
- pll_locked passes a 2-flop synchroniser (locked_s). A change is visible 2 cycles later.
- Outputs are registered and loaded from next-state, so they equal the state decode with no extra latency.
- States (state_o): RESET=0, WAIT_LOCK=1, RUN=2; 3 is unused and recovers to RESET.
- RESET:
  - pll_rst=1, sys_rst=1.
  - cnt increments from 0. At cnt==RST_CYCLES-1, go to WAIT_LOCK and clear cnt.
  - pll_rst is high for exactly RST_CYCLES cycles per attempt.
  - relock_req is ignored.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - cnt (timeout) increments every cycle.
  - stab increments while locked_s=1 and resets to 0 when locked_s=0.
  - stab reaching LOCK_STABLE: go to RUN.
  - cnt reaching LOCK_TIMEOUT-1 without that: go to RESET and increment retry_cnt, saturating at all-ones.
  - Both in the same cycle: RUN wins and there is no retry increment.
  - relock_req: go to RESET with no retry increment; it has priority over RUN and timeout.
- RUN:
  - pll_rst=0, sys_rst=0, ready=1.
  - locked_s=0: go to RESET and set lock_lost.
  - relock_req alone: go to RESET, lock_lost unchanged.
  - Both in the same cycle: go to RESET, lock_lost set.
- clr_status zeroes lock_lost and retry_cnt. A set or increment in the same cycle wins: the value after is 1, or 1 respectively.
- Counter widths are $clog2 of the largest bound. No wrap is possible because every count ends in a transition.
- rst asserted mid-attempt or in RUN returns immediately to reset values.

Optional Feature:
- Macro: PLL_SEQ_GLITCH_FILTER_EN.
- Defined: in RUN, lock loss requires LOSS_FILTER consecutive cycles of locked_s=0. The filter counter resets on any locked_s=1. Shorter dropouts are ignored and do not set lock_lost.
- Undefined: a single locked_s=0 cycle in RUN is lock loss, and LOSS_FILTER is unused.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state typedef (2-bit enum RESET/WAIT_LOCK/RUN);
  - the state_o encoding constants;
  - default parameter values.
- One sub-module is natural: sync_2ff, a reusable single-bit 2-flop synchroniser with async active-high reset, used for pll_locked.

Test Plan:
Bench uses RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, RETRY_W=4, LOSS_FILTER=4.
- Clean start: release rst; pll_locked rises at cycle 10 and stays -> pll_rst high cycles 0-3; ready and sys_rst=0 at cycle 4+32? No: WAIT entered at cycle 4, locked_s=1 at 12, RUN at 20; sys_rst=0 and ready=1 from cycle 20; retry_cnt=0.
- Timeout: pll_locked held 0 -> WAIT_LOCK exits after 32 cycles; retry_cnt steps 1,2,…,15; saturates at 15 after 16+ attempts; sys_rst stays 1.
- Lock loss in RUN: drop pll_locked 1 cycle (macro off) -> RESET 2 cycles later, sys_rst=1, lock_lost=1. Pulse clr_status -> lock_lost=0. Relock reaches RUN again.
- Glitch filter (macro on): 3-cycle dropout -> stays RUN, lock_lost=0. 4-cycle dropout -> RESET, lock_lost=1.
- relock_req in RUN -> RESET next cycle, lock_lost=0, retry_cnt unchanged. relock_req during RESET -> pll_rst width still exactly 4.
- Simultaneous events: clr_status in the same cycle as a timeout -> retry_cnt=1. Async rst pulse mid-WAIT_LOCK -> all outputs at reset values within the same cycle.
